// File: rtl/memory_latency_pkg.sv
// Shared definitions for the memory latency pipe.
// - entry_t   : one in-flight request slot (tag, type, size, remaining countdown)
// - LFSR_TAPS : feedback mask of the 16-bit Galois jitter LFSR
// - sat_add   : unsigned add clamped to a given bit width, used for the
//               latency sum and for the performance counters
// The entry field widths below are the default tag/size/latency widths of
// memory_latency_pipe; a build that overrides those widths must change
// these constants to match.
package memory_latency_pkg;

    localparam int unsigned MLP_TAG_WIDTH  = 4;
    localparam int unsigned MLP_SIZE_WIDTH = 16;
    localparam int unsigned MLP_LAT_WIDTH  = 16;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic [MLP_TAG_WIDTH-1:0]  tag;
        logic                      is_dram;
        logic [MLP_SIZE_WIDTH-1:0] size;
        logic [MLP_LAT_WIDTH-1:0]  cnt;
    } entry_t;

    // Adds a and b and clamps the result to 2^width-1 (width <= 64).
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned width);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << width) - 65'd1;
        if (sum > lim) begin
            return lim[63:0];
        end else begin
            return sum[63:0];
        end
    endfunction

endpackage

// File: rtl/memory_latency_lfsr.sv
// 16-bit Galois LFSR used to add pseudo-random jitter to request latencies.
// Ports:
//   clk       - clock
//   reset     - asynchronous active-high reset, loads SEED
//   advance_i - step the LFSR once at the next clock edge
//   value_o   - current LFSR state
// The current value is consumed by the accepting request before it steps,
// so the very first accepted request sees SEED.
module memory_latency_lfsr
    import memory_latency_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance_i,
    output logic [15:0] value_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next state: right shift, folding the taps in when bit 0 falls out.
    always_comb begin
        if (advance_i) begin
            if (lfsr_q[0]) begin
                lfsr_d = {1'b0, lfsr_q[15:1]} ^ LFSR_TAPS;
            end else begin
                lfsr_d = {1'b0, lfsr_q[15:1]};
            end
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/memory_latency_pipe.sv
// In-order, multi-outstanding memory latency model.
// Requests are accepted into a circular queue of MAX_OUTSTANDING entries;
// each entry counts down its own latency from the moment it is accepted and
// the head is presented on resp_* once its countdown reaches zero.
// Ports:
//   clk, reset                        - clock, asynchronous active-high reset
//   req_valid/req_ready               - request handshake
//   req_is_dram/req_tag/req_size_bytes- request attributes
//   resp_valid/resp_ready             - response handshake (head of queue)
//   resp_tag/resp_is_dram/resp_size_bytes - head attributes, 0 when not valid
//   cfg_latency_sram/dram, cfg_use_cfg_latencies, cfg_jitter_mask
//                                     - latency configuration, sampled on accept
//   total_reqs..bp_cycles             - saturating performance counters
//   occupancy/max_occupancy/busy      - fill level, high-water mark, non-empty
module memory_latency_pipe
    import memory_latency_pkg::*;
#(
    parameter int unsigned SIZE_WIDTH          = MLP_SIZE_WIDTH,
    parameter int unsigned TAG_WIDTH           = MLP_TAG_WIDTH,
    parameter int unsigned MAX_OUTSTANDING     = 4,
    parameter int unsigned LAT_WIDTH           = MLP_LAT_WIDTH,
    parameter int unsigned LATENCY_SRAM_CYCLES = 2,
    parameter int unsigned LATENCY_DRAM_CYCLES = 30,
    parameter int unsigned CNT_WIDTH           = 32,
    parameter logic [15:0] LFSR_SEED           = 16'hACE1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_is_dram,
    input  logic [TAG_WIDTH-1:0]               req_tag,
    input  logic [SIZE_WIDTH-1:0]              req_size_bytes,
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic [TAG_WIDTH-1:0]               resp_tag,
    output logic                               resp_is_dram,
    output logic [SIZE_WIDTH-1:0]              resp_size_bytes,
    input  logic [LAT_WIDTH-1:0]               cfg_latency_sram,
    input  logic [LAT_WIDTH-1:0]               cfg_latency_dram,
    input  logic                               cfg_use_cfg_latencies,
    input  logic [LAT_WIDTH-1:0]               cfg_jitter_mask,
    output logic [CNT_WIDTH-1:0]               total_reqs,
    output logic [CNT_WIDTH-1:0]               total_resp,
    output logic [CNT_WIDTH-1:0]               sram_reqs,
    output logic [CNT_WIDTH-1:0]               dram_reqs,
    output logic [CNT_WIDTH-1:0]               stall_cycles,
    output logic [CNT_WIDTH-1:0]               busy_cycles,
    output logic [CNT_WIDTH-1:0]               bp_cycles,
    output logic [$clog2(MAX_OUTSTANDING):0]   occupancy,
    output logic [$clog2(MAX_OUTSTANDING):0]   max_occupancy,
    output logic                               busy
);

    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned OCC_W = PTR_W + 1;

    localparam logic [OCC_W-1:0]         OCC_ZERO   = {OCC_W{1'b0}};
    localparam logic [OCC_W-1:0]         OCC_ONE    = OCC_W'(1'b1);
    localparam logic [OCC_W-1:0]         OCC_FULL   = OCC_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0]         PTR_ONE    = PTR_W'(1'b1);
    localparam logic [LAT_WIDTH-1:0]     LAT_ZERO   = {LAT_WIDTH{1'b0}};
    localparam logic [LAT_WIDTH-1:0]     LAT_ONE    = LAT_WIDTH'(1'b1);
    localparam logic [LAT_WIDTH-1:0]     LAT_SRAM_P = LAT_WIDTH'(LATENCY_SRAM_CYCLES);
    localparam logic [LAT_WIDTH-1:0]     LAT_DRAM_P = LAT_WIDTH'(LATENCY_DRAM_CYCLES);
    localparam logic [MLP_LAT_WIDTH-1:0] CNT_ZERO   = {MLP_LAT_WIDTH{1'b0}};
    localparam logic [MLP_LAT_WIDTH-1:0] CNT_ONE    = MLP_LAT_WIDTH'(1'b1);

    // Saturating +en on a performance counter.
    function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] v,
                                                     input logic en);
        return CNT_WIDTH'(sat_add(64'(v), {63'd0, en}, CNT_WIDTH));
    endfunction

    entry_t               mem_q [MAX_OUTSTANDING];
    entry_t               mem_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic [OCC_W-1:0]     max_occ_q, max_occ_d;

    logic [CNT_WIDTH-1:0] total_reqs_q, total_reqs_d;
    logic [CNT_WIDTH-1:0] total_resp_q, total_resp_d;
    logic [CNT_WIDTH-1:0] sram_reqs_q, sram_reqs_d;
    logic [CNT_WIDTH-1:0] dram_reqs_q, dram_reqs_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;
    logic [CNT_WIDTH-1:0] busy_cyc_q, busy_cyc_d;
    logic [CNT_WIDTH-1:0] bp_q, bp_d;

    logic [15:0]          lfsr_s;
    logic                 accept_s;
    logic                 retire_s;
    logic                 head_mature_s;
    entry_t               head_s;
    entry_t               new_entry_s;
    logic [LAT_WIDTH-1:0] base_lat_s;
    logic [LAT_WIDTH-1:0] jitter_s;
    logic [LAT_WIDTH-1:0] lat_sum_s;
    logic [LAT_WIDTH-1:0] lat_eff_s;

    memory_latency_lfsr #(
        .SEED      (LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .advance_i (accept_s),
        .value_o   (lfsr_s)
    );

    // Ready depends only on the registered fill level, so a retire in the
    // same cycle never frees a slot for an accept when full.
    assign req_ready     = (occ_q != OCC_FULL);
    assign accept_s      = req_valid && req_ready;
    assign head_s        = mem_q[rd_ptr_q];
    assign head_mature_s = (occ_q != OCC_ZERO) && (head_s.cnt == CNT_ZERO);
    assign retire_s      = head_mature_s && resp_ready;

    assign resp_valid      = head_mature_s;
    assign resp_tag        = head_mature_s ? TAG_WIDTH'(head_s.tag)   : {TAG_WIDTH{1'b0}};
    assign resp_is_dram    = head_mature_s ? head_s.is_dram           : 1'b0;
    assign resp_size_bytes = head_mature_s ? SIZE_WIDTH'(head_s.size) : {SIZE_WIDTH{1'b0}};

    assign occupancy     = occ_q;
    assign max_occupancy = max_occ_q;
    assign busy          = (occ_q != OCC_ZERO);
    assign total_reqs    = total_reqs_q;
    assign total_resp    = total_resp_q;
    assign sram_reqs     = sram_reqs_q;
    assign dram_reqs     = dram_reqs_q;
    assign stall_cycles  = stall_q;
    assign busy_cycles   = busy_cyc_q;
    assign bp_cycles     = bp_q;

    // Latency of the request on the input: base + masked LFSR, clamped, and
    // stored as L-1 so that a count of zero means "presentable now".
    always_comb begin
        if (cfg_use_cfg_latencies) begin
            if (req_is_dram) begin
                base_lat_s = cfg_latency_dram;
            end else begin
                base_lat_s = cfg_latency_sram;
            end
        end else begin
            if (req_is_dram) begin
                base_lat_s = LAT_DRAM_P;
            end else begin
                base_lat_s = LAT_SRAM_P;
            end
        end
        jitter_s  = LAT_WIDTH'(lfsr_s) & cfg_jitter_mask;
        lat_sum_s = LAT_WIDTH'(sat_add(64'(base_lat_s), 64'(jitter_s), LAT_WIDTH));
        if (lat_sum_s == LAT_ZERO) begin
            lat_eff_s = LAT_ONE;
        end else begin
            lat_eff_s = lat_sum_s;
        end
        new_entry_s.tag     = MLP_TAG_WIDTH'(req_tag);
        new_entry_s.is_dram = req_is_dram;
        new_entry_s.size    = MLP_SIZE_WIDTH'(req_size_bytes);
        new_entry_s.cnt     = MLP_LAT_WIDTH'(lat_eff_s - LAT_ONE);
    end

    // Queue next state: write the accepted slot, count every other slot down
    // regardless of its position, and advance pointers/fill level.
    always_comb begin
        for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
            mem_d[i] = mem_q[i];
            if (accept_s && (wr_ptr_q == PTR_W'(i))) begin
                mem_d[i] = new_entry_s;
            end else if (mem_q[i].cnt != CNT_ZERO) begin
                mem_d[i].cnt = mem_q[i].cnt - CNT_ONE;
            end else begin
                mem_d[i].cnt = mem_q[i].cnt;
            end
        end
        wr_ptr_d = accept_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = retire_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({accept_s, retire_s})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
        if (occ_d > max_occ_q) begin
            max_occ_d = occ_d;
        end else begin
            max_occ_d = max_occ_q;
        end
    end

    // Performance counter next state.
    always_comb begin
        total_reqs_d = cnt_inc(total_reqs_q, accept_s);
        total_resp_d = cnt_inc(total_resp_q, retire_s);
        sram_reqs_d  = cnt_inc(sram_reqs_q, accept_s && !req_is_dram);
        dram_reqs_d  = cnt_inc(dram_reqs_q, accept_s && req_is_dram);
        stall_d      = cnt_inc(stall_q, req_valid && !req_ready);
        busy_cyc_d   = cnt_inc(busy_cyc_q, occ_q != OCC_ZERO);
        bp_d         = cnt_inc(bp_q, head_mature_s && !resp_ready);
    end

    // Queue storage, pointers and fill level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                mem_q[i] <= '{default: '0};
            end
            wr_ptr_q  <= {PTR_W{1'b0}};
            rd_ptr_q  <= {PTR_W{1'b0}};
            occ_q     <= OCC_ZERO;
            max_occ_q <= OCC_ZERO;
        end else begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            max_occ_q <= max_occ_d;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_reqs_q <= {CNT_WIDTH{1'b0}};
            total_resp_q <= {CNT_WIDTH{1'b0}};
            sram_reqs_q  <= {CNT_WIDTH{1'b0}};
            dram_reqs_q  <= {CNT_WIDTH{1'b0}};
            stall_q      <= {CNT_WIDTH{1'b0}};
            busy_cyc_q   <= {CNT_WIDTH{1'b0}};
            bp_q         <= {CNT_WIDTH{1'b0}};
        end else begin
            total_reqs_q <= total_reqs_d;
            total_resp_q <= total_resp_d;
            sram_reqs_q  <= sram_reqs_d;
            dram_reqs_q  <= dram_reqs_d;
            stall_q      <= stall_d;
            busy_cyc_q   <= busy_cyc_d;
            bp_q         <= bp_d;
        end
    end

endmodule

// File: tb/tb_memory_latency_pipe.sv
// Scoreboard bench for memory_latency_pipe.
// Stimulus computes each accepted request's latency from the configuration
// and a reference LFSR, and queues the expected response with its accept
// edge. The monitor, on every falling edge, derives the expected fill level,
// response validity and counters from that queue and compares.
module tb_memory_latency_pipe;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_is_dram;
    logic [3:0]  req_tag;
    logic [15:0] req_size_bytes;
    logic        resp_valid, resp_ready, resp_is_dram;
    logic [3:0]  resp_tag;
    logic [15:0] resp_size_bytes;
    logic [15:0] cfg_latency_sram, cfg_latency_dram, cfg_jitter_mask;
    logic        cfg_use_cfg_latencies;
    logic [31:0] total_reqs, total_resp, sram_reqs, dram_reqs;
    logic [31:0] stall_cycles, busy_cycles, bp_cycles;
    logic [2:0]  occupancy, max_occupancy;
    logic        busy;

    memory_latency_pipe dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_dram(req_is_dram),
        .req_tag(req_tag), .req_size_bytes(req_size_bytes),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_tag(resp_tag),
        .resp_is_dram(resp_is_dram), .resp_size_bytes(resp_size_bytes),
        .cfg_latency_sram(cfg_latency_sram), .cfg_latency_dram(cfg_latency_dram),
        .cfg_use_cfg_latencies(cfg_use_cfg_latencies), .cfg_jitter_mask(cfg_jitter_mask),
        .total_reqs(total_reqs), .total_resp(total_resp), .sram_reqs(sram_reqs),
        .dram_reqs(dram_reqs), .stall_cycles(stall_cycles), .busy_cycles(busy_cycles),
        .bp_cycles(bp_cycles), .occupancy(occupancy), .max_occupancy(max_occupancy),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int          acc_edge;
        int          lat;
        logic [3:0]  tag;
        logic        is_dram;
        logic [15:0] size;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_lfsr;
    longint      m_tr, m_rs, m_sr, m_dr, m_st, m_bu, m_bp, m_max;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        m_lfsr = SEED;
        m_tr = 0; m_rs = 0; m_sr = 0; m_dr = 0;
        m_st = 0; m_bu = 0; m_bp = 0; m_max = 0;
    endtask

    // Latency from the configuration rules; consumes one LFSR step.
    function automatic int ref_lat(input logic dram);
        int base;
        int l;
        if (cfg_use_cfg_latencies) base = dram ? int'(cfg_latency_dram) : int'(cfg_latency_sram);
        else                       base = dram ? 30 : 2;
        l = base + int'(m_lfsr & cfg_jitter_mask);
        if (l > 65535) l = 65535;
        if (l == 0) l = 1;
        if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
        else           m_lfsr = m_lfsr >> 1;
        return l;
    endfunction

    // Drive one cycle of inputs (called just after a rising edge); a request
    // seen with ready is recorded as accepted at the coming edge.
    task automatic cyc(input logic v, input logic dram, input logic [3:0] tag,
                       input logic [15:0] size, input logic rr, output logic acc);
        exp_t e;
        req_valid = v; req_is_dram = dram; req_tag = tag;
        req_size_bytes = size; resp_ready = rr;
        acc = v && req_ready;
        if (acc) begin
            e.acc_edge = edge_cnt + 1;
            e.lat      = ref_lat(dram);
            e.tag      = tag;
            e.is_dram  = dram;
            e.size     = size;
            sb.push_back(e);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input logic rr);
        logic a;
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 4'd0, 16'd0, rr, a);
    endtask

    task automatic reset_checks(input string tagname);
        chk({tagname, "_resp_valid"}, longint'(resp_valid), 0);
        chk({tagname, "_busy"}, longint'(busy), 0);
        chk({tagname, "_req_ready"}, longint'(req_ready), 1);
        chk({tagname, "_resp_tag"}, longint'(resp_tag), 0);
        chk({tagname, "_resp_size"}, longint'(resp_size_bytes), 0);
        chk({tagname, "_resp_is_dram"}, longint'(resp_is_dram), 0);
        chk({tagname, "_occupancy"}, longint'(occupancy), 0);
        chk({tagname, "_max_occ"}, longint'(max_occupancy), 0);
        chk({tagname, "_total_reqs"}, longint'(total_reqs), 0);
        chk({tagname, "_busy_cycles"}, longint'(busy_cycles), 0);
    endtask

    // Monitor: compares outputs against the scoreboard and advances the
    // model by what the coming edge will accept and retire.
    initial begin
        int     n;
        int     occ_exp;
        logic   exp_valid, acc, ret;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) continue;
            n = edge_cnt;
            occ_exp = 0;
            foreach (sb[i]) if (sb[i].acc_edge <= n) occ_exp++;
            exp_valid = (sb.size() > 0) && (sb[0].acc_edge <= n) &&
                        (n >= sb[0].acc_edge + sb[0].lat - 1);
            chk("occupancy", longint'(occupancy), occ_exp);
            chk("req_ready", longint'(req_ready), (occ_exp != 4) ? 1 : 0);
            chk("busy", longint'(busy), (occ_exp != 0) ? 1 : 0);
            chk("resp_valid", longint'(resp_valid), longint'(exp_valid));
            if (exp_valid && resp_valid) begin
                chk("resp_tag", longint'(resp_tag), longint'(sb[0].tag));
                chk("resp_is_dram", longint'(resp_is_dram), longint'(sb[0].is_dram));
                chk("resp_size", longint'(resp_size_bytes), longint'(sb[0].size));
            end
            chk("total_reqs", longint'(total_reqs), m_tr);
            chk("total_resp", longint'(total_resp), m_rs);
            chk("sram_reqs", longint'(sram_reqs), m_sr);
            chk("dram_reqs", longint'(dram_reqs), m_dr);
            chk("stall_cycles", longint'(stall_cycles), m_st);
            chk("busy_cycles", longint'(busy_cycles), m_bu);
            chk("bp_cycles", longint'(bp_cycles), m_bp);
            chk("max_occupancy", longint'(max_occupancy), m_max);
            acc = req_valid && (occ_exp != 4);
            ret = exp_valid && resp_ready;
            if (acc) begin
                m_tr++;
                if (req_is_dram) m_dr++; else m_sr++;
            end
            if (ret) m_rs++;
            if (req_valid && occ_exp == 4) m_st++;
            if (occ_exp != 0) m_bu++;
            if (exp_valid && !resp_ready) m_bp++;
            if (occ_exp + int'(acc) - int'(ret) > m_max) m_max = occ_exp + int'(acc) - int'(ret);
            if (ret) void'(sb.pop_front());
        end
    end

    initial begin
        logic a;
        int   tries;
        int   guard;
        req_valid = 1'b0; req_is_dram = 1'b0; req_tag = 4'd0; req_size_bytes = 16'd0;
        resp_ready = 1'b1;
        cfg_use_cfg_latencies = 1'b1; cfg_latency_sram = 16'd5;
        cfg_latency_dram = 16'd10; cfg_jitter_mask = 16'd0;
        clear_model();
        reset = 1'b1;
        @(posedge clk); #1;
        reset_checks("reset");
        @(posedge clk); #2;
        reset = 1'b0;

        // Single SRAM request, L=5.
        cyc(1'b1, 1'b0, 4'h1, 16'd64, 1'b1, a);
        idle(8, 1'b1);
        chk("single_total_reqs", longint'(total_reqs), 1);
        chk("single_total_resp", longint'(total_resp), 1);
        chk("single_busy_cycles", longint'(busy_cycles), 5);

        // Four back-to-back DRAM requests fill the queue; a fifth stalls.
        for (int t = 1; t <= 4; t++) cyc(1'b1, 1'b1, 4'(t), 16'd128, 1'b1, a);
        tries = 0;
        do begin
            cyc(1'b1, 1'b1, 4'd5, 16'd256, 1'b1, a);
            tries++;
        end while (!a && tries < 30);
        chk("fifth_accepted", longint'(a), 1);
        chk("max_occupancy_full", longint'(max_occupancy), 4);
        idle(20, 1'b1);

        // Head-of-line: long DRAM then short SRAM.
        cyc(1'b1, 1'b1, 4'd1, 16'd32, 1'b1, a);
        cfg_latency_sram = 16'd2;
        cyc(1'b1, 1'b0, 4'd2, 16'd16, 1'b1, a);
        idle(15, 1'b1);

        // Backpressure on a mature head, then accept and retire together.
        cyc(1'b1, 1'b0, 4'd3, 16'd8, 1'b0, a);
        idle(4, 1'b0);
        cyc(1'b1, 1'b0, 4'd4, 16'd4, 1'b1, a);
        idle(6, 1'b1);

        // Parameter latencies, then with jitter.
        cfg_use_cfg_latencies = 1'b0;
        cyc(1'b1, 1'b0, 4'd5, 16'd1, 1'b1, a);
        cyc(1'b1, 1'b1, 4'd6, 16'd2, 1'b1, a);
        idle(35, 1'b1);
        cfg_jitter_mask = 16'h0007;
        for (int t = 0; t < 6; t++) cyc(1'b1, 1'($urandom_range(0, 1)), 4'(t + 7), 16'(t), 1'b1, a);
        idle(45, 1'b1);

        // Random traffic with mid-flight configuration changes.
        for (int c = 0; c < 400; c++) begin
            if (c % 50 == 0) begin
                cfg_use_cfg_latencies = 1'($urandom_range(0, 1));
                cfg_latency_sram = 16'($urandom_range(0, 6));
                cfg_latency_dram = 16'($urandom_range(0, 15));
                case ($urandom_range(0, 3))
                    0:       cfg_jitter_mask = 16'h0000;
                    1:       cfg_jitter_mask = 16'h0007;
                    2:       cfg_jitter_mask = 16'h0003;
                    default: cfg_jitter_mask = 16'h000F;
                endcase
            end
            cyc(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 99) < 75), a);
        end
        idle(60, 1'b1);

        // Reset with three entries in flight.
        cfg_use_cfg_latencies = 1'b1; cfg_latency_dram = 16'd10; cfg_jitter_mask = 16'd0;
        for (int t = 0; t < 3; t++) cyc(1'b1, 1'b1, 4'(t + 10), 16'd99, 1'b1, a);
        idle(1, 1'b1);
        reset = 1'b1;
        req_valid = 1'b0;
        #1;
        reset_checks("midreset");
        clear_model();
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;
        idle(15, 1'b1);
        cyc(1'b1, 1'b1, 4'd9, 16'd77, 1'b1, a);
        cyc(1'b1, 1'b0, 4'd8, 16'd66, 1'b1, a);

        guard = 0;
        while (sb.size() != 0 && guard < 300) begin
            idle(1, 1'b1);
            guard++;
        end
        chk("drain_empty", longint'(sb.size()), 0);
        idle(2, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_latency_pipe.md
Name: memory_latency_pipe

Overview:
- Multi-outstanding successor to memory_latency_injector, used in fast tile benches and tile models.
- Accepts tagged SRAM/DRAM requests into an in-order queue of up to MAX_OUTSTANDING entries.
- Each entry counts down its own latency, with optional LFSR jitter; responses retire in acceptance order under resp_ready backpressure.
- Exposes saturating performance counters for CSR readout.

Parameters:
- SIZE_WIDTH, 16, request/response byte-size width
- TAG_WIDTH, 4, request tag width, echoed on response
- MAX_OUTSTANDING, 4, queue depth; power of two, ≥2
- LAT_WIDTH, 16, latency and countdown width
- LATENCY_SRAM_CYCLES, 2, SRAM latency when cfg_use_cfg_latencies=0
- LATENCY_DRAM_CYCLES, 30, DRAM latency when cfg_use_cfg_latencies=0
- CNT_WIDTH, 32, performance counter width
- LFSR_SEED, 16'hACE1, jitter LFSR reset value; must be nonzero

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  queue can accept
- req_is_dram  in  1  1=DRAM, 0=SRAM
- req_tag  in  TAG_WIDTH  request tag
- req_size_bytes  in  SIZE_WIDTH  request size
- resp_valid  out  1  head entry matured
- resp_ready  in  1  consumer accepts response
- resp_tag  out  TAG_WIDTH  head tag
- resp_is_dram  out  1  head type
- resp_size_bytes  out  SIZE_WIDTH  head size
- cfg_latency_sram  in  LAT_WIDTH  CSR SRAM latency
- cfg_latency_dram  in  LAT_WIDTH  CSR DRAM latency
- cfg_use_cfg_latencies  in  1  select CSR (1) or parameter (0) latencies
- cfg_jitter_mask  in  LAT_WIDTH  ANDed with LFSR and added to latency; 0 disables jitter
- total_reqs, total_resp, sram_reqs, dram_reqs  out  CNT_WIDTH each  accepted/retired/by-type counts
- stall_cycles  out  CNT_WIDTH  cycles with req_valid && !req_ready
- busy_cycles  out  CNT_WIDTH  cycles with occupancy ≥1
- bp_cycles  out  CNT_WIDTH  cycles with resp_valid && !resp_ready
- occupancy  out  $clog2(MAX_OUTSTANDING)+1  entries in flight
- max_occupancy  out  same width  high-water mark
- busy  out  1  occupancy≠0

Behaviour:
- Reset, asynchronous: queue empty, LFSR=LFSR_SEED, all counters/occupancy/max_occupancy=0. Outputs at reset: resp_valid=0, busy=0, req_ready=1, resp_tag/resp_is_dram/resp_size_bytes=0.
- Accept: req_valid && req_ready at a clk edge. req_ready = (occupancy != MAX_OUTSTANDING), combinational from state only.
- When full, no accept occurs even if the head retires in the same cycle.
- Latency load on accept:
  - base = cfg_use_cfg_latencies ? cfg_latency_(type) : LATENCY_(type)_CYCLES.
  - L = base + (lfsr & cfg_jitter_mask), saturating at 2^LAT_WIDTH−1. L=0 is treated as 1.
  - The configuration in effect at the accept edge is latched; later cfg changes do not affect in-flight entries.
- LFSR: 16-bit Galois, taps 0xB400. It advances only on accept, after its value is used.
- Countdown: an entry is stored with cnt=L−1 and decrements every cycle while >0, independent of head position. An entry is mature when cnt==0.
- Response: resp_valid = head mature. With an empty queue and resp_ready=1, accept at edge e gives resp_valid high in the cycle after edge e+L−1, i.e. L cycles after accept.
- Retire: resp_valid && resp_ready at an edge.
- Strict in-order: a mature entry waits behind an immature head; there is no bypass.
- resp_* fields are held stable while resp_valid && !resp_ready.
- Back-to-back: requests accepted on consecutive edges with equal L retire on consecutive cycles (throughput 1/cycle).
- Simultaneous accept and retire: occupancy is unchanged; both counters increment.
- Counters saturate at all-ones and never wrap. max_occupancy updates with the post-edge occupancy.
- Storage: circular buffer with wr_ptr/rd_ptr of $clog2(MAX_OUTSTANDING) bits that wrap naturally; occupancy is tracked separately.

Decomposition:
- Package memory_latency_pkg:
  - entry struct {tag, is_dram, size, cnt}
  - LFSR taps constant
  - sat_add function for the latency sum and counters
- One sub-module, memory_latency_lfsr: 16-bit Galois LFSR with advance enable and seed parameter.
- Queue, countdown and counters stay in memory_latency_pipe.

Test Plan:
- Single request timing: cfg_use=1, cfg_latency_sram=5, mask=0; one SRAM accept at edge 10 → resp_valid first high after edge 14; retire; total_reqs=total_resp=1; busy_cycles=5.
- Pipelined DRAM: 4 DRAM accepts on consecutive edges, cfg_latency_dram=10, resp_ready=1 → 4 responses on 4 consecutive cycles in tag order; max_occupancy=4; 5th request stalls; stall_cycles increments once per blocked cycle.
- Head-of-line: DRAM(10, tag1) then SRAM(2, tag2) next edge → tag2 is not presented until the cycle after tag1 retires; order is tag1, tag2.
- Backpressure: mature head with resp_ready=0 for 3 cycles → resp_* stable, bp_cycles=3, retire on cycle 4; accept+retire in the same cycle leaves occupancy unchanged.
- Parameter path and jitter: cfg_use=0 → SRAM latency 2, DRAM 30. Then mask=0x7 → latencies equal base+(LFSR&7) matching the reference LFSR sequence from seed 0xACE1.
- Reset mid-operation: assert reset with 3 entries in flight → same-cycle resp_valid=0, occupancy=0, counters=0; no stale response appears after release.
